// File: rtl/fmt_vec_driver.sv
// fmt_vec_driver
// ----------------------------------------------------------------------------
// Multi-channel, vector-buffered pin-format driver for the ASIC tester.
// Drive vectors are queued in a DEPTH-entry FIFO and one vector is popped on
// each leading edge of the tester CYCLE strobe. Every channel is shaped by its
// own 2-bit format mode (R0, R1, DNRZ_L, DNRZ_T). Format modes are
// double-buffered: FF_LOAD fills a shadow copy that becomes active at the next
// leading edge. CYCLE is sampled on CLK, never used as a clock.
//
// Optional feature macro: FMT_VEC_CYCLE_SYNC_EN
//   defined   - CYCLE passes through a 2-flop synchronizer before edge
//               detection, so every CYCLE-driven response lags by 2 CLKs.
//   undefined - CYCLE is sampled directly and must be CLK-synchronous.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset (flushes the FIFO)
//   CYCLE      in   tester cycle strobe; rise = lead, fall = trail
//   START      in   pulse, IDLE -> ARMED (clears UNDERRUN and VEC_COUNT)
//   STOP       in   pulse, any state -> IDLE (wins over START and lead)
//   WR_EN      in   push WR_DATA into the FIFO
//   WR_DATA    in   WIDTH-bit drive vector
//   FF_LOAD    in   load FF_MODE into the shadow mode register
//   FF_MODE    in   2*WIDTH per-channel modes, channel i = [2i+1:2i]
//   Q          out  registered formatted pin drive
//   FULL       out  FIFO full
//   EMPTY      out  FIFO empty
//   LEVEL      out  FIFO occupancy 0..DEPTH
//   BUSY       out  state != IDLE
//   UNDERRUN   out  sticky, a pop was needed in RUN with an empty FIFO
//   OVERFLOW   out  sticky, a write was attempted while FULL
//   VEC_COUNT  out  vectors popped since START, saturating
// ----------------------------------------------------------------------------
module fmt_vec_driver #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CYCLE,
    input  logic                     START,
    input  logic                     STOP,
    input  logic                     WR_EN,
    input  logic [WIDTH-1:0]         WR_DATA,
    input  logic                     FF_LOAD,
    input  logic [2*WIDTH-1:0]       FF_MODE,
    output logic [WIDTH-1:0]         Q,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     BUSY,
    output logic                     UNDERRUN,
    output logic                     OVERFLOW,
    output logic [CNT_W-1:0]         VEC_COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] FMT_R0     = 2'b00;
    localparam logic [1:0] FMT_R1     = 2'b01;
    localparam logic [1:0] FMT_DNRZ_L = 2'b10;
    localparam logic [1:0] FMT_DNRZ_T = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_UNDER
    } state_t;

    state_t               state;
    logic                 cycle_s;
    logic                 cyc_q;
    logic                 lead;
    logic                 trail;
    logic [WIDTH-1:0]     mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [WIDTH-1:0]     head;
    logic [WIDTH-1:0]     vec_reg;
    logic [2*WIDTH-1:0]   mode_active;
    logic [2*WIDTH-1:0]   mode_shadow;
    logic                 mode_pending;
    logic [2*WIDTH-1:0]   mode_now;
    logic [WIDTH-1:0]     vec_now;
    logic [WIDTH-1:0]     q_next;
    logic                 push;
    logic                 pop;
    logic                 fmt_active;

`ifdef FMT_VEC_CYCLE_SYNC_EN
    logic sync_1;
    logic sync_2;

    // Two-flop synchronizer for an asynchronous CYCLE strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= CYCLE;
            sync_2 <= sync_1;
        end
    end

    assign cycle_s = sync_2;
`else
    assign cycle_s = CYCLE;
`endif

    assign lead  = cycle_s & ~cyc_q;
    assign trail = ~cycle_s & cyc_q;

    assign FULL  = (LEVEL == LW'(DEPTH));
    assign EMPTY = (LEVEL == '0);
    assign BUSY  = (state != ST_IDLE);
    assign head  = mem[rd_ptr];

    // EMPTY is the registered occupancy, so a write landing in the same
    // cycle as a lead on an empty FIFO is never bypassed to the output.
    assign push = WR_EN & ~FULL;
    assign pop  = lead & ~EMPTY & ~STOP &
                  ((state == ST_ARMED) || (state == ST_RUN));

    // Formatting runs in RUN/UNDERRUN, and also on the lead that moves ARMED
    // into RUN. STOP freezes Q.
    assign fmt_active = ~STOP & ((state == ST_RUN) || (state == ST_UNDER) ||
                                 ((state == ST_ARMED) && pop));

    // A pending shadow becomes active on this lead, so the lead itself is
    // already shaped by the new modes.
    assign mode_now = (lead && mode_pending) ? mode_shadow : mode_active;
    assign vec_now  = pop ? head : vec_reg;

    // Per-channel format decode; trail edges use the vector held in vec_reg.
    always_comb begin
        q_next = Q;
        for (int i = 0; i < WIDTH; i++) begin
            if (lead) begin
                if (mode_now[2*i +: 2] != FMT_DNRZ_T) begin
                    q_next[i] = vec_now[i];
                end
            end else if (trail) begin
                case (mode_now[2*i +: 2])
                    FMT_R0:     q_next[i] = 1'b0;
                    FMT_R1:     q_next[i] = 1'b1;
                    FMT_DNRZ_L: q_next[i] = Q[i];
                    FMT_DNRZ_T: q_next[i] = vec_reg[i];
                    default:    q_next[i] = Q[i];
                endcase
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers are flushed.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= WR_DATA;
        end
    end

    // Control state, FIFO pointers, mode buffers, flags and registered Q.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_IDLE;
            cyc_q        <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            LEVEL        <= '0;
            vec_reg      <= '0;
            mode_active  <= '0;
            mode_shadow  <= '0;
            mode_pending <= 1'b0;
            Q            <= '0;
            UNDERRUN     <= 1'b0;
            OVERFLOW     <= 1'b0;
            VEC_COUNT    <= '0;
        end else begin
            cyc_q <= cycle_s;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                vec_reg <= head;
                if (VEC_COUNT != '1) begin
                    VEC_COUNT <= VEC_COUNT + CNT_W'(1);
                end
            end

            case ({push, pop})
                2'b10:   LEVEL <= LEVEL + LW'(1);
                2'b01:   LEVEL <= LEVEL - LW'(1);
                default: LEVEL <= LEVEL;
            endcase

            if (WR_EN && FULL) begin
                OVERFLOW <= 1'b1;
            end

            // A load coinciding with a lead only refills the shadow; the
            // pending flag re-arms so it applies at the following lead.
            if (lead && mode_pending) begin
                mode_active  <= mode_shadow;
                mode_pending <= 1'b0;
            end
            if (FF_LOAD) begin
                mode_shadow  <= FF_MODE;
                mode_pending <= 1'b1;
            end

            if (fmt_active) begin
                Q <= q_next;
            end

            if (STOP) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (START) begin
                            state     <= ST_ARMED;
                            UNDERRUN  <= 1'b0;
                            VEC_COUNT <= '0;
                        end
                    end
                    ST_ARMED: begin
                        if (pop) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (lead && EMPTY) begin
                            state    <= ST_UNDER;
                            UNDERRUN <= 1'b1;
                        end
                    end
                    ST_UNDER: begin
                        state <= ST_UNDER;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fmt_vec_driver.sv
// tb_fmt_vec_driver
// ----------------------------------------------------------------------------
// Self-checking bench for fmt_vec_driver (WIDTH=8, DEPTH=16, CNT_W=16).
// Each row holds the inputs for one CLK cycle plus the outputs expected right
// after that edge. Rows are applied in order; the expected part is queued on a
// scoreboard when the row is driven and popped when the DUT output is sampled.
// With FMT_VEC_CYCLE_SYNC_EN defined a short latency sequence is run instead.
// ----------------------------------------------------------------------------
module tb_fmt_vec_driver;

    logic        CLK;
    logic        RST;
    logic        CYCLE;
    logic        START;
    logic        STOP;
    logic        WR_EN;
    logic [7:0]  WR_DATA;
    logic        FF_LOAD;
    logic [15:0] FF_MODE;
    logic [7:0]  Q;
    logic        FULL;
    logic        EMPTY;
    logic [4:0]  LEVEL;
    logic        BUSY;
    logic        UNDERRUN;
    logic        OVERFLOW;
    logic [15:0] VEC_COUNT;

    typedef struct {
        logic        rst;
        logic        cyc;
        logic        start;
        logic        stop;
        logic        wr;
        logic [7:0]  data;
        logic        ld;
        logic [15:0] mode;
        logic [7:0]  e_q;
        logic [4:0]  e_level;
        logic        e_busy;
        logic        e_und;
        logic        e_ovf;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    vec_t cur;

    int total_checks = 0;
    int passed_checks = 0;

    fmt_vec_driver #(.WIDTH(8), .DEPTH(16), .CNT_W(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CYCLE     (CYCLE),
        .START     (START),
        .STOP      (STOP),
        .WR_EN     (WR_EN),
        .WR_DATA   (WR_DATA),
        .FF_LOAD   (FF_LOAD),
        .FF_MODE   (FF_MODE),
        .Q         (Q),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .LEVEL     (LEVEL),
        .BUSY      (BUSY),
        .UNDERRUN  (UNDERRUN),
        .OVERFLOW  (OVERFLOW),
        .VEC_COUNT (VEC_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs for the next row; everything not named is deasserted.
    task automatic drv(input logic rst, input logic cyc, input logic start,
                       input logic stop, input logic wr, input logic [7:0] data,
                       input logic ld, input logic [15:0] mode);
        cur.rst   = rst;
        cur.cyc   = cyc;
        cur.start = start;
        cur.stop  = stop;
        cur.wr    = wr;
        cur.data  = data;
        cur.ld    = ld;
        cur.mode  = mode;
    endtask

    // Expected outputs for the row started by drv, then append it.
    task automatic ex(input logic [7:0] q, input int level, input logic busy,
                      input logic und, input logic ovf, input int cnt);
        cur.e_q     = q;
        cur.e_level = 5'(level);
        cur.e_busy  = busy;
        cur.e_und   = und;
        cur.e_ovf   = ovf;
        cur.e_cnt   = 16'(cnt);
        vecs.push_back(cur);
    endtask

    task automatic checkField(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] expv);
        total_checks++;
        if (act !== expv) begin
            $display("[TB] FAIL row %0d %s: got 0x%0h, expected 0x%0h", idx, name, act, expv);
        end else begin
            passed_checks++;
        end
    endtask

    task automatic applyStimulus(input vec_t r);
        RST     = r.rst;
        CYCLE   = r.cyc;
        START   = r.start;
        STOP    = r.stop;
        WR_EN   = r.wr;
        WR_DATA = r.data;
        FF_LOAD = r.ld;
        FF_MODE = r.mode;
        sb.push_back(r);
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input int idx);
        vec_t e;
        if (sb.size() == 0) begin
            total_checks++;
            $display("[TB] FAIL row %0d scoreboard: got empty queue, expected an entry", idx);
        end else begin
            e = sb.pop_front();
            checkField("Q",         idx, 32'(Q),         32'(e.e_q));
            checkField("LEVEL",     idx, 32'(LEVEL),     32'(e.e_level));
            checkField("FULL",      idx, 32'(FULL),      32'(e.e_level == 5'd16));
            checkField("EMPTY",     idx, 32'(EMPTY),     32'(e.e_level == 5'd0));
            checkField("BUSY",      idx, 32'(BUSY),      32'(e.e_busy));
            checkField("UNDERRUN",  idx, 32'(UNDERRUN),  32'(e.e_und));
            checkField("OVERFLOW",  idx, 32'(OVERFLOW),  32'(e.e_ovf));
            checkField("VEC_COUNT", idx, 32'(VEC_COUNT), 32'(e.e_cnt));
        end
    endtask

    task automatic runRows();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end
        vecs.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST = 1'b0; CYCLE = 1'b0; START = 1'b0; STOP = 1'b0;
        WR_EN = 1'b0; WR_DATA = '0; FF_LOAD = 1'b0; FF_MODE = '0;
        cur = '{default: '0};

`ifdef FMT_VEC_CYCLE_SYNC_EN
        // Q follows a CYCLE rise/fall two CLKs later than the direct build.
        drv(1,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,0,0,0,0,0);
        drv(0,0,0,0,1,8'h3C,0,16'h0000); ex(8'h00,1,0,0,0,0);
        drv(0,0,1,0,0,8'h00,0,16'h0000); ex(8'h00,1,1,0,0,0);
        drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'h00,1,1,0,0,0);
        drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'h00,1,1,0,0,0);
        drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'h3C,0,1,0,0,1);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h3C,0,1,0,0,1);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h3C,0,1,0,0,1);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,0,1,0,0,1);
        runRows();
`else
        // Reset, three vectors in R0: lead drives v, trail returns to 0.
        drv(1,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,0,0,0,0,0);
        drv(0,0,0,0,1,8'h01,0,16'h0000); ex(8'h00,1,0,0,0,0);
        drv(0,0,0,0,1,8'h02,0,16'h0000); ex(8'h00,2,0,0,0,0);
        drv(0,0,0,0,1,8'h03,0,16'h0000); ex(8'h00,3,0,0,0,0);
        drv(0,0,1,0,0,8'h00,0,16'h0000); ex(8'h00,3,1,0,0,0);
        drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'h01,2,1,0,0,1);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,2,1,0,0,1);
        drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'h02,1,1,0,0,2);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,1,1,0,0,2);
        drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'h03,0,1,0,0,3);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,0,1,0,0,3);
        // Underrun: held vector re-driven, later data is not popped.
        drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'h03,0,1,1,0,3);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,0,1,1,0,3);
        drv(0,0,0,0,1,8'h55,0,16'h0000); ex(8'h00,1,1,1,0,3);
        drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'h03,1,1,1,0,3);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,1,1,1,0,3);
        drv(0,0,0,1,0,8'h00,0,16'h0000); ex(8'h00,1,0,1,0,3);
        drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'h00,1,0,1,0,3);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,1,0,1,0,3);
        drv(0,0,1,0,0,8'h00,0,16'h0000); ex(8'h00,1,1,0,0,0);
        drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'h55,0,1,0,0,1);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,0,1,0,0,1);
        // ch0 R1, ch1 DNRZ_L, ch2 DNRZ_T; vectors 0x00 then 0x07.
        drv(0,0,0,0,1,8'h00,1,16'h0039); ex(8'h00,1,1,0,0,1);
        drv(0,0,0,0,1,8'h07,0,16'h0000); ex(8'h00,2,1,0,0,1);
        drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'h00,1,1,0,0,2);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h01,1,1,0,0,2);
        drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'h03,0,1,0,0,3);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h07,0,1,0,0,3);
        // Back to R0, then all-DNRZ_T loaded on the same cycle as a lead.
        drv(0,0,0,0,1,8'hAA,1,16'h0000); ex(8'h07,1,1,0,0,3);
        drv(0,0,0,0,1,8'h0F,0,16'h0000); ex(8'h07,2,1,0,0,3);
        drv(0,0,0,0,1,8'hF0,0,16'h0000); ex(8'h07,3,1,0,0,3);
        drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'hAA,2,1,0,0,4);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,2,1,0,0,4);
        drv(0,1,0,0,0,8'h00,1,16'hFFFF); ex(8'h0F,1,1,0,0,5);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,1,1,0,0,5);
        drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'h00,0,1,0,0,6);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'hF0,0,1,0,0,6);
        drv(0,0,0,0,0,8'h00,1,16'h0000); ex(8'hF0,0,1,0,0,6);
        // Fill to DEPTH, 17th write and push-at-full-with-pop both dropped.
        for (int i = 0; i < 16; i++) begin
            drv(0,0,0,0,1,8'(8'h80 + i),0,16'h0000); ex(8'hF0,i+1,1,0,0,6);
        end
        drv(0,0,0,0,1,8'h5A,0,16'h0000); ex(8'hF0,16,1,0,1,6);
        drv(0,1,0,0,1,8'h66,0,16'h0000); ex(8'h80,15,1,0,1,7);
        for (int k = 1; k < 16; k++) begin
            drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,16-k,1,0,1,6+k);
            drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'(8'h80 + k),15-k,1,0,1,7+k);
        end
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,0,1,0,1,22);
        drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'h8F,0,1,1,1,22);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,0,1,1,1,22);
        drv(0,0,0,1,0,8'h00,0,16'h0000); ex(8'h00,0,0,1,1,22);
        runRows();

        // Write and lead together on an empty FIFO: no bypass, stays ARMED.
        drv(0,0,1,0,0,8'h00,0,16'h0000); ex(8'h00,0,1,0,1,0);
        drv(0,1,0,0,1,8'h42,0,16'h0000); ex(8'h00,1,1,0,1,0);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,1,1,0,1,0);
        drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'h42,0,1,0,1,1);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,0,1,0,1,1);
        // STOP beats START and a lead in the same cycle: no pop, Q holds.
        drv(0,0,0,0,1,8'h99,0,16'h0000); ex(8'h00,1,1,0,1,1);
        drv(0,1,1,1,0,8'h00,0,16'h0000); ex(8'h00,1,0,0,1,1);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,1,0,0,1,1);
        runRows();

        // Reset while running with LEVEL=5 flushes everything.
        drv(0,0,1,0,0,8'h00,0,16'h0000); ex(8'h00,1,1,0,1,0);
        for (int i = 1; i <= 5; i++) begin
            drv(0,0,0,0,1,8'(i),0,16'h0000); ex(8'h00,i+1,1,0,1,0);
        end
        drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'h99,5,1,0,1,1);
        drv(1,1,0,0,0,8'h00,0,16'h0000); ex(8'h00,0,0,0,0,0);
        drv(0,1,0,0,0,8'h00,0,16'h0000); ex(8'h00,0,0,0,0,0);
        drv(0,0,0,0,0,8'h00,0,16'h0000); ex(8'h00,0,0,0,0,0);
        runRows();
`endif

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
